// File: rtl/ftdi_fifo_port_pkg.sv
// Shared types and default strobe timing for the FT232H 245-FIFO handshake engine.
package ftdi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_STROBE,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_RECOVER
  } state_e;

  localparam int DEF_RD_PULSE = 3;
  localparam int DEF_WR_SETUP = 1;
  localparam int DEF_WR_PULSE = 2;
  localparam int DEF_WR_HOLD  = 1;
  localparam int DEF_RECOVER  = 3;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // States in which the FPGA owns ADBUS.
  function automatic logic drives_bus(input state_e s);
    return (s == ST_WR_SETUP) || (s == ST_WR_STROBE) || (s == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/ftdi_fifo_port_sync2.sv
// Two-flop synchronizer for the asynchronous FTDI flags; resets to the inactive (high) level.
module sync2 (
  input  logic clock,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ftdi_fifo_port.sv
// FT232H async 245-FIFO strobe engine: turns RXF#/TXE#/RD#/WR# handshakes into rx and tx
// valid/ready byte streams and is the sole owner of the ADBUS output enable.
module ftdi_fifo_port
  import ftdi_pkg::*;
#(
  parameter int RD_PULSE = DEF_RD_PULSE,
  parameter int WR_SETUP = DEF_WR_SETUP,
  parameter int WR_PULSE = DEF_WR_PULSE,
  parameter int WR_HOLD  = DEF_WR_HOLD,
  parameter int RECOVER  = DEF_RECOVER
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic       rxf,
  input  logic       txe,
  input  logic [7:0] adbus_in,
  output logic       ftdi_rd,
  output logic       ftdi_wr,
  output logic [7:0] adbus_out,
  output logic       adbus_tri,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_count
);

  localparam int MAX_T = max_of(max_of(max_of(RD_PULSE, WR_SETUP), max_of(WR_PULSE, WR_HOLD)), RECOVER);
  localparam int CNT_W = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] LD_RD_PULSE = CNT_W'(RD_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_WR_SETUP = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_WR_PULSE = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_WR_HOLD  = CNT_W'(WR_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_RECOVER  = CNT_W'(RECOVER - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_rd_q, last_rd_d;

  logic             rxf_s, txe_s;
  logic             rd_elig, wr_elig;
  logic             start_wr, rd_done, wr_done;

  logic             ftdi_rd_q, ftdi_wr_q, adbus_tri_q;
  logic [7:0]       adbus_out_q, adbus_out_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_count_q, rx_count_d;
  logic [7:0]       tx_hold_q, tx_hold_d;
  logic             tx_full_q, tx_full_d;

  sync2 u_sync_rxf (
    .clock   (clock),
    .reset_n (reset_n),
    .d_i     (rxf),
    .q_o     (rxf_s)
  );

  sync2 u_sync_txe (
    .clock   (clock),
    .reset_n (reset_n),
    .d_i     (txe),
    .q_o     (txe_s)
  );

  // Eligibility looks only at registered rx_valid, so a byte consumed this cycle
  // cannot trigger a read until the following cycle.
  assign rd_elig = en && !rxf_s && !rx_valid_q;
  assign wr_elig = en && !txe_s && tx_full_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rd_d = last_rd_q;
    start_wr  = 1'b0;
    rd_done   = 1'b0;
    wr_done   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rd_elig && (!wr_elig || !last_rd_q)) begin
          state_d   = ST_RD_STROBE;
          cnt_d     = LD_RD_PULSE;
          last_rd_d = 1'b1;
        end else if (wr_elig) begin
          state_d   = ST_WR_SETUP;
          cnt_d     = LD_WR_SETUP;
          last_rd_d = 1'b0;
          start_wr  = 1'b1;
        end
      end

      ST_RD_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
          cnt_d   = LD_RECOVER;
          rd_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WR_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_STROBE;
          cnt_d   = LD_WR_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WR_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_HOLD;
          cnt_d   = LD_WR_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WR_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
          cnt_d   = LD_RECOVER;
          wr_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_count_d  = rx_count_q;
    tx_hold_d   = tx_hold_q;
    tx_full_d   = tx_full_q;
    adbus_out_d = adbus_out_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    // Sample on the last strobe cycle, when the FTDI data has long settled.
    if (rd_done) begin
      rx_data_d  = adbus_in;
      rx_valid_d = 1'b1;
      rx_count_d = rx_count_q + 8'd1;
    end

    if (wr_done) begin
      tx_full_d = 1'b0;
    end else if (tx_valid && !tx_full_q) begin
      tx_hold_d = tx_data;
      tx_full_d = 1'b1;
    end

    if (start_wr) begin
      adbus_out_d = tx_hold_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_rd_q   <= 1'b0;
      ftdi_rd_q   <= 1'b1;
      ftdi_wr_q   <= 1'b1;
      adbus_tri_q <= 1'b0;
      adbus_out_q <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_count_q  <= 8'h00;
      tx_hold_q   <= 8'h00;
      tx_full_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_rd_q   <= last_rd_d;
      // Pin drivers are registered from the next state so the strobes are glitch-free.
      ftdi_rd_q   <= (state_d != ST_RD_STROBE);
      ftdi_wr_q   <= (state_d != ST_WR_STROBE);
      adbus_tri_q <= drives_bus(state_d);
      adbus_out_q <= adbus_out_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_count_q  <= rx_count_d;
      tx_hold_q   <= tx_hold_d;
      tx_full_q   <= tx_full_d;
    end
  end

  assign ftdi_rd   = ftdi_rd_q;
  assign ftdi_wr   = ftdi_wr_q;
  assign adbus_tri = adbus_tri_q;
  assign adbus_out = adbus_out_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_count  = rx_count_q;
  assign tx_ready  = !tx_full_q;

endmodule

// File: tb/tb_ftdi_fifo_port.sv
// Directed bench for ftdi_fifo_port: one task per scenario, cycle positions counted at negedges.
module tb_ftdi_fifo_port;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b1;
  logic       rxf = 1'b1;
  logic       txe = 1'b1;
  logic [7:0] adbus_in = 8'h00;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  logic       ftdi_rd, ftdi_wr, adbus_tri, rx_valid, tx_ready;
  logic [7:0] adbus_out, rx_data, rx_count;

  int tests = 0;
  int fails = 0;
  int overlap = 0;

  always #10 clock = ~clock;

  ftdi_fifo_port dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .rxf       (rxf),
    .txe       (txe),
    .adbus_in  (adbus_in),
    .ftdi_rd   (ftdi_rd),
    .ftdi_wr   (ftdi_wr),
    .adbus_out (adbus_out),
    .adbus_tri (adbus_tri),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_count  (rx_count)
  );

  always @(negedge clock) begin
    if (adbus_tri && !ftdi_rd) overlap++;
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    tests++;
    if ({ftdi_rd, ftdi_wr, adbus_tri, rx_valid, tx_ready} !== 5'b11001) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 11001", {ftdi_rd, ftdi_wr, adbus_tri, rx_valid, tx_ready});
    end
    tests++;
    if (adbus_out !== 8'h00) begin fails++; $display("FAIL reset_adbus_out: got %h expected 00", adbus_out); end
    tests++;
    if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    tests++;
    if (rx_count !== 8'h00) begin fails++; $display("FAIL reset_rx_count: got %h expected 00", rx_count); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    $display("[TB] reset: done");
  endtask

  task automatic test_single_read();
    int rd_first = -1, rd_low = 0, rxv_first = -1, rxv_cnt = 0;
    logic [7:0] got = 8'h00;
    @(negedge clock);
    rx_ready = 1'b1; adbus_in = 8'h5A; rxf = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (!ftdi_rd) begin
        rd_low++;
        if (rd_first < 0) rd_first = k;
        rxf = 1'b1;
        adbus_in = (rd_low == 3) ? 8'hA5 : 8'h5A;
      end
      if (rx_valid) begin
        rxv_cnt++;
        if (rxv_first < 0) begin rxv_first = k; got = rx_data; end
      end
    end
    tests++;
    if (rd_first != 3) begin fails++; $display("FAIL read_rd_start: got %0d expected 3", rd_first); end
    tests++;
    if (rd_low != 3) begin fails++; $display("FAIL read_rd_width: got %0d expected 3", rd_low); end
    tests++;
    if (rxv_first != 6) begin fails++; $display("FAIL read_latency: got %0d expected 6", rxv_first); end
    tests++;
    if (rxv_cnt != 1) begin fails++; $display("FAIL read_valid_pulses: got %0d expected 1", rxv_cnt); end
    tests++;
    if (got !== 8'hA5) begin fails++; $display("FAIL read_data: got %h expected a5", got); end
    tests++;
    if (rx_count !== 8'd1) begin fails++; $display("FAIL read_count: got %0d expected 1", rx_count); end
    $display("[TB] single read: rd_low=%0d data=%h count=%0d", rd_low, got, rx_count);
  endtask

  task automatic test_single_write();
    int tri_first = -1, tri_cnt = 0, wr_first = -1, wr_low = 0, bad_data = 0, rdy_bad = 0;
    logic rdy_k1 = 1'b1, rdy_after = 1'b0;
    bit seen_fall = 0;
    @(negedge clock);
    tx_data = 8'h3C; tx_valid = 1'b1; txe = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 1) begin tx_valid = 1'b0; tx_data = 8'hFF; rdy_k1 = tx_ready; end
      if (adbus_tri) begin
        tri_cnt++;
        if (tri_first < 0) tri_first = k;
        if (adbus_out !== 8'h3C) bad_data++;
        if (tx_ready !== 1'b0) rdy_bad++;
      end else if (tri_cnt > 0 && !seen_fall) begin
        seen_fall = 1; rdy_after = tx_ready;
      end
      if (!ftdi_wr) begin
        wr_low++;
        if (wr_first < 0) wr_first = k;
        txe = 1'b1;
      end
    end
    tests++;
    if (rdy_k1 !== 1'b0) begin fails++; $display("FAIL write_ready_drop: got %b expected 0", rdy_k1); end
    tests++;
    if (tri_first != 3) begin fails++; $display("FAIL write_tri_start: got %0d expected 3", tri_first); end
    tests++;
    if (tri_cnt != 4) begin fails++; $display("FAIL write_tri_width: got %0d expected 4", tri_cnt); end
    tests++;
    if (wr_first != 4 || wr_low != 2) begin
      fails++; $display("FAIL write_strobe: got start %0d width %0d expected start 4 width 2", wr_first, wr_low);
    end
    tests++;
    if (bad_data != 0) begin fails++; $display("FAIL write_data_stable: got %0d bad cycles expected 0", bad_data); end
    tests++;
    if (rdy_bad != 0 || rdy_after !== 1'b1) begin
      fails++; $display("FAIL write_ready_return: got busy-high %0d after %b expected 0 and 1", rdy_bad, rdy_after);
    end
    $display("[TB] single write: tri=%0d wr_low=%0d", tri_cnt, wr_low);
  endtask

  task automatic test_contention();
    logic [7:0] wbytes [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
    logic seq [16];
    int n = 0, wi = 0, pushed = 0, bad_order = 0, bad_wdata = 0;
    logic prev_rd = 1'b1, prev_wr = 1'b1, rdy_prev = 1'b0;
    @(negedge clock);
    tx_data = wbytes[0]; tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0; pushed = 1;
    rx_ready = 1'b1; rxf = 1'b0; txe = 1'b0;
    for (int k = 0; k < 300 && wi < 4; k++) begin
      @(negedge clock);
      if (tx_valid && rdy_prev) begin tx_valid = 1'b0; pushed++; end
      if (!tx_valid && pushed < 4 && tx_ready) begin tx_valid = 1'b1; tx_data = wbytes[pushed]; end
      rdy_prev = tx_ready;
      if (!ftdi_rd && prev_rd) begin
        if (n < 16) seq[n] = 1'b1;
        n++;
      end
      if (!ftdi_wr && prev_wr) begin
        if (n < 16) seq[n] = 1'b0;
        n++;
        if (adbus_out !== wbytes[wi]) bad_wdata++;
        wi++;
      end
      prev_rd = ftdi_rd; prev_wr = ftdi_wr;
    end
    rxf = 1'b1; txe = 1'b1;
    repeat (12) @(negedge clock);
    for (int i = 0; i < 8 && i < n; i++) begin
      if (seq[i] !== ((i % 2) == 0)) bad_order++;
    end
    tests++;
    if (wi != 4) begin fails++; $display("FAIL contention_timeout: got %0d writes expected 4", wi); end
    tests++;
    if (n != 8) begin fails++; $display("FAIL contention_strobes: got %0d expected 8", n); end
    tests++;
    if (bad_order != 0) begin fails++; $display("FAIL contention_order: got %0d misordered expected 0", bad_order); end
    tests++;
    if (bad_wdata != 0) begin fails++; $display("FAIL contention_wdata: got %0d bad bytes expected 0", bad_wdata); end
    tests++;
    if (overlap != 0) begin fails++; $display("FAIL bus_overlap: got %0d cycles expected 0", overlap); end
    tests++;
    if (rx_count !== 8'd5) begin fails++; $display("FAIL contention_count: got %0d expected 5", rx_count); end
    $display("[TB] contention: strobes=%0d writes=%0d count=%0d", n, wi, rx_count);
  endtask

  task automatic test_backpressure();
    int falls = 0, rxv_hi = 0, k_second = -1;
    logic prev_rd = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0; adbus_in = 8'h77; rxf = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (!ftdi_rd && prev_rd) falls++;
      prev_rd = ftdi_rd;
      if (rx_valid) rxv_hi++;
    end
    tests++;
    if (falls != 1) begin fails++; $display("FAIL bp_single_read: got %0d reads expected 1", falls); end
    tests++;
    if (rxv_hi != 35 || rx_data !== 8'h77) begin
      fails++; $display("FAIL bp_valid_held: got %0d cycles data %h expected 35 cycles data 77", rxv_hi, rx_data);
    end
    rx_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (!ftdi_rd && prev_rd) begin
        falls++;
        if (k_second < 0) k_second = k;
        rxf = 1'b1;
      end
      prev_rd = ftdi_rd;
    end
    tests++;
    if (k_second != 2) begin fails++; $display("FAIL bp_resume: got cycle %0d expected 2", k_second); end
    tests++;
    if (falls != 2 || rx_count !== 8'd7) begin
      fails++; $display("FAIL bp_total: got %0d reads count %0d expected 2 reads count 7", falls, rx_count);
    end
    $display("[TB] backpressure: reads=%0d resume=%0d count=%0d", falls, k_second, rx_count);
  endtask

  task automatic test_reset_mid_write();
    int k = 0;
    @(negedge clock);
    tx_data = 8'hC3; tx_valid = 1'b1; txe = 1'b0;
    @(negedge clock);
    tx_valid = 1'b0;
    while (ftdi_wr !== 1'b0 && k < 20) begin @(negedge clock); k++; end
    tests++;
    if (ftdi_wr !== 1'b0) begin fails++; $display("FAIL rst_wait_strobe: got %b expected 0", ftdi_wr); end
    reset_n = 1'b0;
    #1;
    tests++;
    if (ftdi_wr !== 1'b1 || adbus_tri !== 1'b0) begin
      fails++; $display("FAIL rst_async: got wr %b tri %b expected wr 1 tri 0", ftdi_wr, adbus_tri);
    end
    txe = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    tests++;
    if (tx_ready !== 1'b1 || ftdi_wr !== 1'b1 || adbus_tri !== 1'b0) begin
      fails++; $display("FAIL rst_release: got ready %b wr %b tri %b expected 1 1 0", tx_ready, ftdi_wr, adbus_tri);
    end
    tests++;
    if (rx_count !== 8'd0) begin fails++; $display("FAIL rst_count: got %0d expected 0", rx_count); end
    $display("[TB] reset mid-write: ready=%b count=%0d", tx_ready, rx_count);
  endtask

  task automatic test_disable_wrap();
    int k = 0, rd_low = 1, falls = 0, f1 = -1, f2 = -1;
    logic prev_rd = 1'b0;
    @(negedge clock);
    rx_ready = 1'b1; en = 1'b1; adbus_in = 8'h42; rxf = 1'b0;
    while (ftdi_rd !== 1'b0 && k < 20) begin @(negedge clock); k++; end
    tests++;
    if (ftdi_rd !== 1'b0) begin fails++; $display("FAIL dis_wait_strobe: got %b expected 0", ftdi_rd); end
    en = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clock);
      if (!ftdi_rd) rd_low++;
      if (!ftdi_rd && prev_rd) falls++;
      prev_rd = ftdi_rd;
    end
    tests++;
    if (rd_low != 3 || falls != 0) begin
      fails++; $display("FAIL dis_complete: got width %0d new reads %0d expected 3 and 0", rd_low, falls);
    end
    tests++;
    if (rx_count !== 8'd1 || rx_valid !== 1'b0) begin
      fails++; $display("FAIL dis_count: got %0d valid %b expected 1 valid 0", rx_count, rx_valid);
    end
    en = 1'b1;
    k = 0;
    while (falls < 255 && k < 4000) begin
      @(negedge clock);
      k++;
      if (!ftdi_rd && prev_rd) begin
        falls++;
        if (falls == 1) f1 = k;
        if (falls == 2) f2 = k;
        if (falls == 255) rxf = 1'b1;
      end
      prev_rd = ftdi_rd;
    end
    repeat (12) @(negedge clock);
    tests++;
    if (falls != 255) begin fails++; $display("FAIL wrap_timeout: got %0d reads expected 255", falls); end
    tests++;
    if (f2 - f1 != 7) begin fails++; $display("FAIL read_spacing: got %0d expected 7", f2 - f1); end
    tests++;
    if (rx_count !== 8'd0) begin fails++; $display("FAIL wrap_count: got %0d expected 0", rx_count); end
    $display("[TB] disable/wrap: reads=%0d spacing=%0d count=%0d", falls, f2 - f1, rx_count);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_backpressure();
    test_reset_mid_write();
    test_disable_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
